// File: rtl/mux_select_arbiter_pkg.sv
// Shared constants for the two-requester mux select arbiter and its
// integration with two_one_mux.
package mux_select_arbiter_pkg;

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] GRANT_A = 2'b01;
  localparam logic [1:0] GRANT_B = 2'b10;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  function automatic int unsigned hold_width(input int unsigned max_hold);
    return $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/mux_select_arbiter_hold_timer.sv
// Grant hold counter: clears on request, counts while enabled, saturates at
// MAX_HOLD and flags the last permitted cycle (MAX_HOLD-1).
module hold_timer
  import mux_select_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned W = hold_width(MAX_HOLD);
  localparam logic [W-1:0] TC_VAL  = W'(MAX_HOLD - 1);
  localparam logic [W-1:0] SAT_VAL = W'(MAX_HOLD);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != SAT_VAL)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter driving the S input of two_one_mux (A -> 0, B -> 1).
// Outputs are registered from the next state, so a grant shows one cycle later.
module mux_select_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic Clk,
  input  logic Rst,
  input  logic ReqA,
  input  logic ReqB,
  input  logic Done,
  output logic S,
  output logic GntA,
  output logic GntB,
  output logic Busy
);

  import mux_select_arbiter_pkg::*;

  logic [1:0] state;
  logic [1:0] next_state;
  logic       last_b;
  logic       release_now;
  logic       tc;
  logic       tmr_clr;
  logic       tmr_en;

  always_comb begin
    next_state  = state;
    release_now = 1'b0;
    case (state)
      IDLE: begin
        if (ReqA && ReqB) begin
          next_state = last_b ? GRANT_A : GRANT_B;
        end else if (ReqA) begin
          next_state = GRANT_A;
        end else if (ReqB) begin
          next_state = GRANT_B;
        end
      end
      GRANT_A: begin
        release_now = Done || !ReqA || tc;
        if (release_now) begin
          next_state = ReqB ? GRANT_B : IDLE;
        end
      end
      GRANT_B: begin
        release_now = Done || !ReqB || tc;
        if (release_now) begin
          next_state = ReqA ? GRANT_A : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Counter restarts on every state change, including a direct handover.
  assign tmr_clr = (next_state != state) || (state == IDLE);
  assign tmr_en  = (state != IDLE);

  hold_timer #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_timer (
    .clk (Clk),
    .rst (Rst),
    .clr (tmr_clr),
    .en  (tmr_en),
    .tc  (tc)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= IDLE;
      last_b <= 1'b1;
      S      <= SEL_A;
      GntA   <= 1'b0;
      GntB   <= 1'b0;
      Busy   <= 1'b0;
    end else begin
      state <= next_state;
      if (release_now) begin
        last_b <= (state == GRANT_B);
      end
      GntA <= (next_state == GRANT_A);
      GntB <= (next_state == GRANT_B);
      Busy <= (next_state != IDLE);
      // S keeps its last granted value while idle.
      if (next_state == GRANT_A) begin
        S <= SEL_A;
      end else if (next_state == GRANT_B) begin
        S <= SEL_B;
      end
    end
  end

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Scoreboard bench: directed vectors push the expected {S,GntA,GntB,Busy}
// for the following edge; a negedge monitor pops and compares.
module tb_mux_select_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4 = 1'b1, a4 = 1'b0, b4 = 1'b0, d4 = 1'b0;
  logic rst1 = 1'b1, a1 = 1'b0, b1 = 1'b0, d1 = 1'b0;
  logic s4, ga4, gb4, bz4;
  logic s1, ga1, gb1, bz1;

  mux_select_arbiter #(.MAX_HOLD(4)) u4 (
    .Clk(clk), .Rst(rst4), .ReqA(a4), .ReqB(b4), .Done(d4),
    .S(s4), .GntA(ga4), .GntB(gb4), .Busy(bz4)
  );

  mux_select_arbiter #(.MAX_HOLD(1)) u1 (
    .Clk(clk), .Rst(rst1), .ReqA(a1), .ReqB(b1), .Done(d1),
    .S(s1), .GntA(ga1), .GntB(gb1), .Busy(bz1)
  );

  // Expected output codes {S, GntA, GntB, Busy}
  localparam logic [3:0] I0 = 4'b0000;
  localparam logic [3:0] I1 = 4'b1000;
  localparam logic [3:0] GA = 4'b0101;
  localparam logic [3:0] GB = 4'b1011;

  typedef struct {
    int         cyc;
    bit         id;
    logic [3:0] val;
    string      nm;
  } exp_t;

  exp_t q[$];
  int cycnt = 0;
  int vecs = 0;
  int errs = 0;

  always @(posedge clk) cycnt <= cycnt + 1;

  always @(negedge clk) begin
    exp_t e;
    logic [3:0] act;
    if (!rst4 && $isunknown({a4, b4, d4})) begin
      $display("FAIL input_known: u4 inputs %b, required known", {a4, b4, d4});
      errs++;
    end
    while (q.size() > 0 && q[0].cyc <= cycnt) begin
      e   = q.pop_front();
      act = e.id ? {s1, ga1, gb1, bz1} : {s4, ga4, gb4, bz4};
      vecs++;
      if (e.cyc != cycnt || act !== e.val) begin
        $display("FAIL %s @cyc %0d (due %0d): got {S,GntA,GntB,Busy}=%b want %b",
                 e.nm, cycnt, e.cyc, act, e.val);
        errs++;
      end
    end
  end

  task automatic step4(input logic r, input logic a, input logic b, input logic d,
                       input logic [3:0] ex, input string nm);
    exp_t e;
    rst4 = r; a4 = a; b4 = b; d4 = d;
    e.cyc = cycnt + 1; e.id = 1'b0; e.val = ex; e.nm = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input logic r, input logic a, input logic b, input logic d,
                       input logic [3:0] ex, input string nm);
    exp_t e;
    rst1 = r; a1 = a; b1 = b; d1 = d;
    e.cyc = cycnt + 1; e.id = 1'b1; e.val = ex; e.nm = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset then idle
    repeat (2) step4(1, 0, 0, 0, I0, "t1_reset");
    repeat (5) step4(0, 0, 0, 0, I0, "t1_idle");

    // 2: A alone, Done in third grant cycle
    repeat (3) step4(0, 1, 0, 0, GA, "t2_grant_a");
    step4(0, 1, 0, 1, I0, "t2_done_release");
    step4(0, 0, 0, 0, I0, "t2_idle_s_hold");

    // 3: both requesting from reset, round robin on timeout
    step4(1, 1, 1, 0, I0, "t3_reset");
    repeat (4) step4(0, 1, 1, 0, GA, "t3_rr_a1");
    repeat (4) step4(0, 1, 1, 0, GB, "t3_rr_b");
    repeat (4) step4(0, 1, 1, 0, GA, "t3_rr_a2");

    // 4: B alone, B drops while A waits -> same-edge handover
    step4(1, 0, 0, 0, I0, "t4_reset");
    repeat (2) step4(0, 0, 1, 0, GB, "t4_grant_b");
    step4(0, 1, 0, 0, GA, "t4_handover");
    step4(0, 0, 0, 0, I0, "t4_drop_a");
    step4(0, 0, 1, 0, GB, "t4_grant_b2");
    step4(0, 0, 1, 1, I1, "t4_done_s_holds_1");
    step4(0, 0, 0, 0, I1, "t4_idle_s_1");

    // 5: reset in second cycle of GRANT_B, then A first; Done with other pending
    repeat (2) step4(0, 0, 1, 0, GB, "t5_grant_b");
    step4(1, 1, 1, 0, I0, "t5_mid_reset");
    step4(0, 1, 1, 0, GA, "t5_a_first");
    step4(0, 1, 1, 1, GB, "t5_done_handover");
    step4(0, 0, 0, 0, I1, "t5_b_drop");

    // Done coincident with timeout, then 1-cycle regrant gap
    repeat (4) step4(0, 1, 0, 0, GA, "tx_hold_a");
    step4(0, 1, 0, 1, I0, "tx_done_and_tc");
    step4(0, 1, 0, 0, GA, "tx_regrant");
    step4(0, 1, 0, 0, GA, "tx_regrant_hold");
    step4(0, 0, 0, 0, I0, "tx_drop");

    // 6: MAX_HOLD=1 alternation and single-requester 1-cycle grants
    step1(1, 1, 1, 0, I0, "t6_reset");
    repeat (3) begin
      step1(0, 1, 1, 0, GA, "t6_alt_a");
      step1(0, 1, 1, 0, GB, "t6_alt_b");
    end
    step1(0, 0, 0, 0, I1, "t6_idle");
    step1(0, 1, 0, 0, GA, "t6_single_a");
    step1(0, 1, 0, 0, I0, "t6_single_tc");
    step1(0, 1, 0, 0, GA, "t6_single_regrant");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      $display("FAIL drain_timeout: %0d expectations left, required 0", q.size());
      errs++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
